gray_frame_ctrl: RTL
====================

Name: gray_frame_ctrl

Overview:
Frame sequencer for the camera RX grayscale path. Arms on a start command and accepts exactly IMG_W x IMG_H RGB565 pixels from the camera stream. Converts each pixel to 8-bit gray and presents it through a one-deep output register, tagged with end-of-line and end-of-frame flags. Sits between the camera pixel capture and the downstream frame buffer writer, and reports frame completion to the system controller.

Parameters:
IMG_W, 320, pixels per line
IMG_H, 240, lines per frame
RGB_PXL_W, 16, input pixel width (RGB565)
GS_PXL_W, 8, gray pixel width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start_i  in  1  frame start command, single-cycle pulse
abort_i  in  1  abort current frame
rgb_pxl_i  in  RGB_PXL_W  RGB565 pixel {R5,G6,B5}
rgb_pxl_vld_i  in  1  input pixel valid
rgb_pxl_rdy_o  out  1  input pixel ready
gs_pxl_o  out  GS_PXL_W  gray pixel
gs_pxl_vld_o  out  1  gray pixel valid
gs_pxl_rdy_i  in  1  downstream ready
gs_eol_o  out  1  qualifies gs_pxl_o as last pixel of a line
gs_eof_o  out  1  qualifies gs_pxl_o as last pixel of the frame
busy_o  out  1  high in any state other than IDLE
frm_done_o  out  1  one-cycle pulse when the frame is fully drained

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low. Reset values: all outputs 0, state IDLE, col/row counters 0, output register empty.
- Gray arithmetic:
  - R8={R5,3'b0}, G8={G6,2'b0}, B8={B5,3'b0}.
  - gray = (R8>>2)+(R8>>5)+(G8>>1)+(G8>>4)+(B8>>4)+(B8>>5), truncated to GS_PXL_W.
  - Conversion is combinational into the output register.
- Handshakes: valid/ready. A transfer happens when vld & rdy are both high in the same cycle. Once valid is asserted, data must be held stable until the transfer.
- States:
  - IDLE: rgb_pxl_rdy_o=0. start_i -> RUN; col and row counters clear.
  - RUN: rgb_pxl_rdy_o = ~gs_pxl_vld_o | gs_pxl_rdy_i (full throughput, 1-cycle latency from input transfer to gs_pxl_vld_o).
    - Each input transfer loads the output register with gray plus flags. gs_eol_o = (col==IMG_W-1). gs_eof_o = eol & (row==IMG_H-1).
    - col increments per transfer and wraps to 0 at IMG_W-1, at which point row increments.
    - An input transfer of the eof pixel -> DRAIN.
  - DRAIN: rgb_pxl_rdy_o=0. On the output transfer of the eof pixel -> DONE.
  - DONE: frm_done_o=1 for exactly one cycle -> IDLE.
- Output register:
  - Loads on input transfer.
  - Clears valid on output transfer with no simultaneous load.
  - A simultaneous load and unload keeps valid high.
- Boundary conditions:
  - start_i outside IDLE is ignored.
  - abort_i, any state -> IDLE next cycle: output valid cleared, counters cleared, no frm_done_o pulse. abort_i has priority over start_i in the same cycle.
  - rgb_pxl_vld_i in IDLE/DRAIN/DONE is not acknowledged. The pixel is not consumed.
  - Reset mid-frame behaves as abort, with all outputs at their reset values.

Optional Feature:
GRAY_FRAME_SUM_EN
- Defined:
  - Adds output frm_sum_o, width GS_PXL_W+$clog2(IMG_W*IMG_H).
  - Cleared on accepted start_i.
  - Accumulates gs_pxl_o on each output transfer.
  - Stable and valid while frm_done_o=1; holds its value until the next start.
  - Abort clears it.
- Undefined: port and accumulator absent. Behaviour is otherwise identical.

Decomposition:
- Shared package gray_frame_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE}.
  - RGB565 field widths R=5, G=6, B=5.
  - GS_PXL_W default.
  - Counter width function (clog2).
- One sub-module, gs_pxl_out_reg: one-deep valid/ready output register carrying {eof, eol, gray}.
- FSM, counters and conversion stay in the top.

Test Plan:
- Single-pixel checks with IMG_W=4, IMG_H=2, downstream always ready:
  - 16'hFFFF -> gs_pxl_o=8'hE8.
  - 16'hF800 -> 8'h45.
  - 16'h07E0 -> 8'h8D.
  - 16'h0000 -> 8'h00.
  - Each arrives 1 cycle after its input transfer.
- Full frame, 4x2, continuous valid: 8 transfers. gs_eol_o on outputs 4 and 8, gs_eof_o only on output 8. frm_done_o pulses 2 cycles after the last input transfer. busy_o drops the following cycle.
- Backpressure: hold gs_pxl_rdy_i=0 for 5 cycles mid-line. Required response:
  - rgb_pxl_rdy_o=0 once the output register is full.
  - gs_pxl_o is stable.
  - No pixel is lost or duplicated; the output sequence matches the input order.
- Input valid in IDLE, and start_i pulsed in RUN: no acknowledge while in IDLE; the restart is ignored and the counters are not disturbed.
- abort_i after 3 pixels: the next cycle shows IDLE, gs_pxl_vld_o=0 and no frm_done_o. A new start_i then yields a clean 8-pixel frame with correct flags.
- With GRAY_FRAME_SUM_EN, 8 pixels of 16'hFFFF -> frm_sum_o = 8 x 232 = 1856 at frm_done_o.

Source files
------------

// File: rtl/gray_frame_pkg.sv
// Shared types and constants for the grayscale frame sequencer.
// State encoding, RGB565 field widths and counter sizing helper.
package gray_frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int R_W          = 5;
  localparam int G_W          = 6;
  localparam int B_W          = 5;
  localparam int GS_PXL_W_DEF = 8;

  // Counter width for a modulus of n; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gs_pxl_out_reg.sv
// One-deep valid/ready output register carrying {eof, eol, gray}.
// A load wins over an unload in the same cycle, so valid stays high.
module gs_pxl_out_reg #(
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_rdy,
  output logic [DATA_W-1:0] o_data,
  output logic              o_vld
);

  logic              r_vld;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_vld  <= 1'b0;
      r_data <= '0;
    end else if (i_load) begin
      r_vld  <= 1'b1;
      r_data <= i_data;
    end else if (r_vld && i_rdy) begin
      r_vld  <= 1'b0;
    end
  end

  assign o_data = r_data;
  assign o_vld  = r_vld;

endmodule

// File: rtl/gray_frame_ctrl.sv
// Frame sequencer: accepts IMG_W x IMG_H RGB565 pixels, emits 8-bit gray with eol/eof tags.
// Optional frame checksum output frm_sum_o when GRAY_FRAME_SUM_EN is defined.
module gray_frame_ctrl
  import gray_frame_pkg::*;
#(
  parameter int IMG_W     = 320,
  parameter int IMG_H     = 240,
  parameter int RGB_PXL_W = 16,
  parameter int GS_PXL_W  = GS_PXL_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [RGB_PXL_W-1:0] rgb_pxl_i,
  input  logic                 rgb_pxl_vld_i,
  output logic                 rgb_pxl_rdy_o,
  output logic [GS_PXL_W-1:0]  gs_pxl_o,
  output logic                 gs_pxl_vld_o,
  input  logic                 gs_pxl_rdy_i,
  output logic                 gs_eol_o,
  output logic                 gs_eof_o,
  output logic                 busy_o,
`ifdef GRAY_FRAME_SUM_EN
  output logic [GS_PXL_W+$clog2(IMG_W*IMG_H)-1:0] frm_sum_o,
`endif
  output logic                 frm_done_o
);

  localparam int COL_W = cnt_w(IMG_W);
  localparam int ROW_W = cnt_w(IMG_H);
  localparam int OUT_W = GS_PXL_W + 2;

  state_t r_state;
  state_t w_state_next;

  logic [COL_W-1:0]    r_col;
  logic [ROW_W-1:0]    r_row;
  logic                w_last_col;
  logic                w_last_row;
  logic                w_ld_eol;
  logic                w_ld_eof;
  logic                w_rgb_rdy;
  logic                w_in_xfer;
  logic                w_out_xfer;
  logic                w_start_acc;
  logic                w_busy;
  logic                w_done;
  logic                w_gs_vld;
  logic [OUT_W-1:0]    w_q_data;
  logic [GS_PXL_W-1:0] w_gs_pxl;
  logic                w_q_eol;
  logic                w_q_eof;

  // RGB565 -> gray: expand fields to 8 bits, then shift-and-add weights.
  logic [R_W-1:0]      w_r5;
  logic [G_W-1:0]      w_g6;
  logic [B_W-1:0]      w_b5;
  logic [7:0]          w_r8;
  logic [7:0]          w_g8;
  logic [7:0]          w_b8;
  logic [9:0]          w_gray_sum;
  logic [GS_PXL_W-1:0] w_gray;

  assign w_r5 = rgb_pxl_i[RGB_PXL_W-1 -: R_W];
  assign w_g6 = rgb_pxl_i[B_W +: G_W];
  assign w_b5 = rgb_pxl_i[0 +: B_W];
  assign w_r8 = {w_r5, 3'b000};
  assign w_g8 = {w_g6, 2'b00};
  assign w_b8 = {w_b5, 3'b000};

  assign w_gray_sum = 10'(w_r8 >> 2) + 10'(w_r8 >> 5)
                    + 10'(w_g8 >> 1) + 10'(w_g8 >> 4)
                    + 10'(w_b8 >> 4) + 10'(w_b8 >> 5);
  assign w_gray     = GS_PXL_W'(w_gray_sum);

  assign w_last_col  = (r_col == COL_W'(IMG_W - 1));
  assign w_last_row  = (r_row == ROW_W'(IMG_H - 1));
  assign w_ld_eol    = w_last_col;
  assign w_ld_eof    = w_last_col & w_last_row;

  assign w_rgb_rdy   = (r_state == RUN) & (~w_gs_vld | gs_pxl_rdy_i);
  assign w_in_xfer   = rgb_pxl_vld_i & w_rgb_rdy;
  assign w_out_xfer  = w_gs_vld & gs_pxl_rdy_i;
  assign w_start_acc = (r_state == IDLE) & start_i & ~abort_i;

  gs_pxl_out_reg #(
    .DATA_W (OUT_W)
  ) u_out_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (abort_i),
    .i_load (w_in_xfer),
    .i_data ({w_ld_eof, w_ld_eol, w_gray}),
    .i_rdy  (gs_pxl_rdy_i),
    .o_data (w_q_data),
    .o_vld  (w_gs_vld)
  );

  assign w_gs_pxl = w_q_data[GS_PXL_W-1:0];
  assign w_q_eol  = w_q_data[GS_PXL_W];
  assign w_q_eof  = w_q_data[GS_PXL_W+1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = (r_state != IDLE);
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) w_state_next = RUN;
      end
      RUN: begin
        if (w_in_xfer && w_ld_eof) w_state_next = DRAIN;
      end
      DRAIN: begin
        if (w_out_xfer && w_q_eof) w_state_next = DONE;
      end
      DONE: begin
        w_done       = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
    // Abort outranks every transition, including a same-cycle start.
    if (abort_i) w_state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || abort_i || w_start_acc) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_in_xfer) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

`ifdef GRAY_FRAME_SUM_EN
  localparam int SUM_W = GS_PXL_W + $clog2(IMG_W * IMG_H);

  logic [SUM_W-1:0] r_sum;

  // Sums what actually leaves the block, so the total is final by DONE.
  always_ff @(posedge clk) begin
    if (!rst_n || abort_i || w_start_acc) begin
      r_sum <= '0;
    end else if (w_out_xfer) begin
      r_sum <= r_sum + SUM_W'(w_gs_pxl);
    end
  end

  assign frm_sum_o = r_sum;
`endif

  assign rgb_pxl_rdy_o = w_rgb_rdy;
  assign gs_pxl_o      = w_gs_pxl;
  assign gs_pxl_vld_o  = w_gs_vld;
  assign gs_eol_o      = w_q_eol;
  assign gs_eof_o      = w_q_eof;
  assign busy_o        = w_busy;
  assign frm_done_o    = w_done;

endmodule
